// File: rtl/encoder_read_scheduler.sv
// Round-robin scheduler sharing one I2C master among NUM_CH encoder/PID channels.
// Latches per-channel angles, pulses read-done, polices timeouts and tracks encoder faults.
module encoder_read_scheduler #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [15:0] GAP_CYCLES     = 16'd1000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [3:0]  FAULT_LIMIT    = 4'd3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [NUM_CH-1:0]   fault_clear,
  output logic                i2c_start,
  output logic [2:0]          i2c_sel,
  output logic                i2c_abort,
  input  logic                i2c_done,
  input  logic                i2c_error,
  input  logic [11:0]         i2c_rdata,
  output logic [12*NUM_CH-1:0] angle_out,
  output logic [NUM_CH-1:0]   rd_done,
  output logic [NUM_CH-1:0]   fault,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] tout_q, tout_d;
  logic        ok_q, ok_d;
  logic        keep_q, keep_d;
  logic [NUM_CH-1:0][11:0] angle_q, angle_d;
  logic [NUM_CH-1:0][3:0]  fail_q, fail_d;
  logic [NUM_CH-1:0]       rd_done_q, rd_done_d;
  logic [NUM_CH-1:0]       fault_q, fault_d;

  logic [7:0]  en_ext;
  logic        grant_found;
  logic [2:0]  grant_idx;
  logic [3:0]  cand_sum;
  logic [3:0]  fail_next;
  logic        timeout_hit;

  assign en_ext      = 8'(ch_enable);
  assign timeout_hit = (tout_q == TIMEOUT_CYCLES - 16'd1);

  // First enabled channel after ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand_sum = {1'b0, ptr_q} + 4'(i);
      if (cand_sum >= 4'(NUM_CH)) cand_sum = cand_sum - 4'(NUM_CH);
      if (!grant_found && en_ext[cand_sum[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[2:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gap_d     = gap_q;
    tout_d    = tout_q;
    ok_d      = ok_q;
    keep_d    = keep_q;
    angle_d   = angle_q;
    fail_d    = fail_q;
    fault_d   = fault_q;
    rd_done_d = '0;
    fail_next = '0;

    case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 16'd1;
        end else if (grant_found) begin
          sel_d   = grant_idx;
          ptr_d   = grant_idx;
          state_d = START;
        end
      end
      START: begin
        tout_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // rdata lands directly in angle_out on the edge into RESULT, so the
        // fresh angle is visible in the same cycle as the rd_done pulse.
        if (i2c_done) begin
          ok_d    = !i2c_error;
          keep_d  = en_ext[sel_q];
          state_d = RESULT;
          if (!i2c_error && en_ext[sel_q]) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (sel_q == 3'(k)) begin
                angle_d[k]   = i2c_rdata;
                rd_done_d[k] = 1'b1;
              end
            end
          end
        end else if (timeout_hit) begin
          ok_d    = 1'b0;
          keep_d  = en_ext[sel_q];
          state_d = RESULT;
        end else begin
          tout_d = tout_q + 16'd1;
        end
      end
      RESULT: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (sel_q == 3'(k) && keep_q) begin
            if (ok_q) begin
              fail_d[k] = '0;
            end else begin
              fail_next = (fail_q[k] == 4'd15) ? 4'd15 : fail_q[k] + 4'd1;
              fail_d[k] = fail_next;
              if (fail_next >= FAULT_LIMIT) fault_d[k] = 1'b1;
            end
          end
        end
        gap_d   = GAP_CYCLES;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (fault_clear[k]) begin
        fault_d[k] = 1'b0;
        fail_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'(NUM_CH - 1);
      sel_q     <= '0;
      gap_q     <= '0;
      tout_q    <= '0;
      ok_q      <= 1'b0;
      keep_q    <= 1'b0;
      angle_q   <= '0;
      fail_q    <= '0;
      rd_done_q <= '0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gap_q     <= gap_d;
      tout_q    <= tout_d;
      ok_q      <= ok_d;
      keep_q    <= keep_d;
      angle_q   <= angle_d;
      fail_q    <= fail_d;
      rd_done_q <= rd_done_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    angle_out = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      angle_out[12*k +: 12] = angle_q[k];
    end
  end

  assign i2c_start = (state_q == START);
  assign i2c_abort = (state_q == WAIT) && !i2c_done && timeout_hit;
  assign i2c_sel   = sel_q;
  assign rd_done   = rd_done_q;
  assign fault     = fault_q;
  assign busy      = (state_q == START) || (state_q == WAIT);

endmodule

// File: tb/tb_encoder_read_scheduler.sv
// Directed bench for encoder_read_scheduler: an I2C responder in the stimulus
// sequence pushes expected reads to a queue that a rd_done monitor pops.
module tb_encoder_read_scheduler;
  localparam int NCH = 4;
  localparam int GAP = 10;
  localparam int TO  = 60;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    ch_enable = '0;
  logic [NCH-1:0]    fault_clear = '0;
  logic              i2c_start;
  logic [2:0]        i2c_sel;
  logic              i2c_abort;
  logic              i2c_done = 1'b0;
  logic              i2c_error = 1'b0;
  logic [11:0]       i2c_rdata = '0;
  logic [12*NCH-1:0] angle_out;
  logic [NCH-1:0]    rd_done;
  logic [NCH-1:0]    fault;
  logic              busy;

  encoder_read_scheduler #(
    .NUM_CH(NCH),
    .GAP_CYCLES(16'(GAP)),
    .TIMEOUT_CYCLES(16'(TO)),
    .FAULT_LIMIT(4'd3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ch_enable(ch_enable), .fault_clear(fault_clear),
    .i2c_start(i2c_start), .i2c_sel(i2c_sel), .i2c_abort(i2c_abort), .i2c_done(i2c_done),
    .i2c_error(i2c_error), .i2c_rdata(i2c_rdata), .angle_out(angle_out), .rd_done(rd_done),
    .fault(fault), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int ch; logic [11:0] d; } exp_t;
  exp_t        q[$];
  logic [11:0] exp_angle[NCH];
  int          last_start = -1;
  int          last_result = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every rd_done pulse must match the oldest outstanding expected read.
  always @(negedge clock) begin
    if (reset_n && rd_done !== '0) begin
      for (int k = 0; k < NCH; k++) begin
        if (rd_done[k]) begin
          chk($sformatf("rd_done_pending_ch%0d", k), 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_done_channel", k, e.ch);
            chk($sformatf("rd_angle_ch%0d", k), angle_out[12*k +: 12], e.d);
          end
        end
      end
    end
  end

  task automatic check_angles();
    for (int k = 0; k < NCH; k++)
      chk($sformatf("angle_ch%0d", k), angle_out[12*k +: 12], exp_angle[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, i2c_start, 0);
    chk({tag, "_abort"}, i2c_abort, 0);
    chk({tag, "_sel"}, i2c_sel, 0);
    chk({tag, "_angle"}, 32'(angle_out != '0), 0);
    chk({tag, "_rd_done"}, rd_done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_start(input int ch, output bit ok);
    bit seen;
    seen = 0;
    for (int i = 0; i < GAP + 30 && !seen; i++) begin
      @(negedge clock);
      seen = i2c_start;
    end
    chk($sformatf("start_seen_ch%0d", ch), seen, 1);
    ok = seen;
    if (seen) begin
      chk("grant_sel", i2c_sel, ch);
      chk("busy_in_start", busy, 1);
      if (last_result >= 0) chk("gap_after_result", 32'(cyc - last_result >= GAP + 2), 1);
      last_start = cyc;
    end
  endtask

  // mode 0: success, 1: NACK, 2: no answer, 3: channel disabled before done
  task automatic serve(input int ch, input int mode, input logic [11:0] data);
    bit ok;
    bit seen;
    int s;
    wait_start(ch, ok);
    if (!ok) return;
    s = cyc;
    if (mode == 2) begin
      seen = 0;
      for (int i = 0; i < TO + 10 && !seen; i++) begin
        @(negedge clock);
        seen = i2c_abort;
      end
      chk("abort_seen", seen, 1);
      chk("abort_latency", cyc - s, TO);
      last_result = cyc + 1;
      repeat (3) @(negedge clock);
      chk("abort_pulse_ended", i2c_abort, 0);
    end else begin
      repeat (2) @(negedge clock);
      if (mode == 3) ch_enable[ch] = 1'b0;
      repeat (18) @(negedge clock);
      chk("no_early_abort", i2c_abort, 0);
      if (mode == 0) begin
        exp_t e;
        e.ch = ch;
        e.d  = data;
        q.push_back(e);
        exp_angle[ch] = data;
      end
      i2c_done  = 1'b1;
      i2c_error = (mode == 1);
      i2c_rdata = data;
      last_result = cyc + 1;
      @(negedge clock);
      i2c_done  = 1'b0;
      i2c_error = 1'b0;
      @(negedge clock);
      chk("rd_done_drained", q.size(), 0);
    end
  endtask

  initial begin : stim
    bit ok;
    int en_c;
    for (int k = 0; k < NCH; k++) exp_angle[k] = '0;

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_no_enable_busy", busy, 0);

    // All channels, round-robin 0,1,2,3,0
    ch_enable = 4'hF;
    en_c = cyc;
    serve(0, 0, 12'h100);
    chk("first_grant_latency", last_start - en_c, 1);
    serve(1, 0, 12'h101);
    serve(2, 0, 12'h102);
    serve(3, 0, 12'h103);
    serve(0, 0, 12'h200);
    check_angles();

    // Only channels 1 and 3
    ch_enable = 4'b1010;
    serve(1, 0, 12'h111);
    serve(3, 0, 12'h113);
    serve(1, 0, 12'h121);
    serve(3, 0, 12'h123);
    check_angles();

    // Channel 2 never answers
    ch_enable = 4'b0110;
    serve(1, 0, 12'h131);
    serve(2, 2, 12'h000);
    chk("fault_after_1_timeout", fault, 4'b0000);
    serve(1, 0, 12'h141);
    serve(2, 2, 12'h000);
    chk("fault_after_2_timeouts", fault, 4'b0000);
    serve(1, 0, 12'h151);
    serve(2, 2, 12'h000);
    chk("fault_after_3_timeouts", fault, 4'b0100);
    serve(1, 0, 12'h161);
    serve(2, 0, 12'h262);
    chk("fault_sticky_after_good_read", fault, 4'b0100);
    check_angles();
    fault_clear = 4'b0100;
    @(negedge clock);
    fault_clear = '0;
    chk("fault_cleared_ch2", fault, 4'b0000);

    // NACKs on channel 1; success resets the count
    ch_enable = 4'b0010;
    serve(1, 1, 12'h7AA);
    serve(1, 1, 12'h7AB);
    serve(1, 0, 12'h171);
    chk("fault_after_err_err_ok", fault, 4'b0000);
    serve(1, 1, 12'h7AC);
    serve(1, 1, 12'h7AD);
    chk("fault_after_reset_count_2err", fault, 4'b0000);
    serve(1, 1, 12'h7AE);
    chk("fault_at_limit_ch1", fault, 4'b0010);
    fault_clear = 4'b0010;
    @(negedge clock);
    fault_clear = '0;
    chk("fault_cleared_ch1", fault, 4'b0000);
    check_angles();

    // Channel 0 disabled while in WAIT
    ch_enable = 4'b0011;
    serve(0, 3, 12'h3AA);
    serve(1, 0, 12'h181);
    check_angles();

    // Reset during WAIT, then a stale done
    ch_enable = 4'hF;
    wait_start(2, ok);
    repeat (5) @(negedge clock);
    chk("busy_in_wait", busy, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    ch_enable = '0;
    for (int k = 0; k < NCH; k++) exp_angle[k] = '0;
    last_result = -1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    i2c_done  = 1'b1;
    i2c_rdata = 12'h555;
    @(negedge clock);
    i2c_done = 1'b0;
    @(negedge clock);
    chk("stale_done_busy", busy, 0);
    check_angles();
    ch_enable = 4'hF;
    en_c = cyc;
    serve(0, 0, 12'h1F0);
    chk("post_reset_grant_latency", last_start - en_c, 1);
    serve(1, 0, 12'h1F1);
    check_angles();

    chk("queue_empty_at_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
